// File: rtl/ram_dma_pkg.sv
// Shared definitions for the ram_dma block-transfer engine.
// Controller state encoding and transfer-mode encodings.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_counter.sv
// Loadable word index counter with terminal-count compare (count+1 == limit).
// The count doubles as the externally visible words_done value.
module ram_dma_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] limit,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] limit_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      count   <= '0;
      limit_q <= limit;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  // count never exceeds limit-1, so count+1 cannot overflow WIDTH bits.
  assign last = ((count + WIDTH'(1)) == limit_q);

endmodule

// File: rtl/ram_dma.sv
// Block-transfer engine driving a single-port synchronous RAM: COPY
// (read/write pairs, ascending) or FILL (one write per cycle) with wrapping addresses.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ADDRESS_WIDTH-1:0] src_addr,
  input  logic [ADDRESS_WIDTH-1:0] dst_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0]    fill_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   words_done,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam int CW = ADDRESS_WIDTH + 1;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] src_q;
  logic [ADDRESS_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     pass_q;
  logic [CW-1:0]            count;
  logic                     last;
  logic                     load;
  logic                     inc;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [ADDRESS_WIDTH-1:0] idx_next;

  assign load = (state == ST_IDLE) && start;
  assign inc  = (state == ST_WRITE) || (state == ST_FILL);

  ram_dma_counter #(.WIDTH(CW)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .limit (length),
    .inc   (inc),
    .count (count),
    .last  (last)
  );

  assign words_done = count;
  assign idx        = count[ADDRESS_WIDTH-1:0];
  assign idx_next   = idx + ADDRESS_WIDTH'(1);

  // Read data is registered inside the RAM, so COPY writes forward it straight through.
  assign mem_dataIn = pass_q ? mem_dataOut : data_q;

  // RAM-side outputs are registered: each branch sets them for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      pass_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_wEn  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            if (length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              state    <= ST_READ;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end else begin
              state    <= ST_FILL;
              busy     <= 1'b1;
              mem_wEn  <= 1'b1;
              mem_addr <= dst_addr;
              data_q   <= fill_data;
            end
          end
        end
        ST_READ: begin
          state    <= ST_WRITE;
          mem_wEn  <= 1'b1;
          mem_addr <= dst_q + idx;
          pass_q   <= 1'b1;
        end
        ST_WRITE: begin
          pass_q  <= 1'b0;
          mem_wEn <= 1'b0;
          if (last) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_addr <= '0;
          end else begin
            state    <= ST_READ;
            mem_addr <= src_q + idx_next;
          end
        end
        ST_FILL: begin
          if (last) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_wEn  <= 1'b0;
            mem_addr <= '0;
            data_q   <= '0;
          end else begin
            mem_addr <= dst_q + idx_next;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          mem_wEn  <= 1'b0;
          mem_addr <= '0;
          data_q   <= '0;
          pass_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: behavioural RAM, array reference model,
// directed vector table, random transfers and a mid-transfer reset sequence.
module tb_ram_dma;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic [DW-1:0] fill_data;
  logic          busy;
  logic          done;
  logic [AW:0]   words_done;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  // Bench-side RAM with a preload port used only while the DUT is idle.
  logic [DW-1:0] ram [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  logic [DW-1:0] model_ram [DEPTH];

  int checks = 0;
  int failures = 0;

  ram_dma #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .fill_data   (fill_data),
    .busy        (busy),
    .done        (done),
    .words_done  (words_done),
    .mem_wEn     (mem_wEn),
    .mem_addr    (mem_addr),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    else mem_dataOut <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    model_ram[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic compare_ram(input string name);
    int mism;
    int first;
    mism = 0;
    first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== model_ram[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (mism != 0) $display("  first differing address 0x%0h", first);
    check({name, "_ram_mismatches"}, 64'(mism), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_wen"}, 64'(mem_wEn), 64'd0);
    check({name, "_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_datain"}, 64'(mem_dataIn), 64'd0);
  endtask

  // Runs one transfer and checks timing, write sequence, words_done and RAM contents.
  task automatic run_transfer(input string name, input logic m, input logic [AW-1:0] s,
                              input logic [AW-1:0] d, input logic [AW:0] n,
                              input logic [DW-1:0] f, input int exp_busy,
                              input int exp_done, input bit poke);
    logic [AW-1:0] exp_wa [$];
    logic [DW-1:0] exp_wd [$];
    logic [AW-1:0] sa, da;
    int busy_n, wen_n, done_at, wr_err, budget;
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < int'(n); i++) begin
      sa = s + AW'(i);
      da = d + AW'(i);
      model_ram[da] = m ? f : model_ram[sa];
      exp_wa.push_back(da);
      exp_wd.push_back(model_ram[da]);
    end
    @(negedge clk);
    start = 1'b1;
    mode = m;
    src_addr = s;
    dst_addr = d;
    length = n;
    fill_data = f;
    @(negedge clk);
    start = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length = (AW + 1)'($urandom);
    fill_data = $urandom;
    mode = ~m;
    busy_n = 0;
    wen_n = 0;
    done_at = 0;
    wr_err = 0;
    budget = 2 * int'(n) + 10;
    for (int k = 1; k <= budget; k++) begin
      if (busy) busy_n++;
      if (mem_wEn) begin
        if (wen_n >= exp_wa.size() || mem_addr !== exp_wa[wen_n] ||
            mem_dataIn !== exp_wd[wen_n]) wr_err++;
        wen_n++;
      end
      if (done) begin
        done_at = k;
        break;
      end
      if (poke && k == 3) begin
        start = 1'b1;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length = 13'd2;
      end
      if (poke && k == 4) start = 1'b0;
      @(negedge clk);
    end
    check({name, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({name, "_write_count"}, 64'(wen_n), 64'(n));
    check({name, "_write_seq_errors"}, 64'(wr_err), 64'd0);
    check({name, "_words_done"}, 64'(words_done), 64'(n));
    @(negedge clk);
    check_idle_outputs({name, "_after"});
    check({name, "_words_done_hold"}, 64'(words_done), 64'(n));
    compare_ram(name);
  endtask

  typedef struct {
    logic          m;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW:0]   n;
    logic [DW-1:0] f;
    int            exp_busy;
    int            exp_done;
    bit            poke;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic          rm;
    logic [AW:0]   rn;
    logic [AW-1:0] rs, rd;
    int            eb;

    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    fill_data = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    vecs[0] = '{1'b0, 12'h010, 12'h100, 13'd4,    32'h0,         8,    9,    1'b0};
    vecs[1] = '{1'b1, 12'h000, 12'hFFE, 13'd4,    32'hDEADBEEF,  4,    5,    1'b0};
    vecs[2] = '{1'b0, 12'h200, 12'h280, 13'd0,    32'h0,         0,    1,    1'b0};
    vecs[3] = '{1'b0, 12'h020, 12'h021, 13'd3,    32'h0,         6,    7,    1'b0};
    vecs[4] = '{1'b0, 12'h050, 12'h300, 13'd4,    32'h0,         8,    9,    1'b1};
    vecs[5] = '{1'b1, 12'h000, 12'h500, 13'd0,    32'h12345678,  0,    1,    1'b0};
    vecs[6] = '{1'b0, 12'hFFD, 12'h400, 13'd5,    32'h0,         10,   11,   1'b0};
    vecs[7] = '{1'b1, 12'h000, 12'h123, 13'd4096, 32'hA5A5C3C3,  4096, 4097, 1'b0};

    @(negedge clk);
    pre_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pre_addr = AW'(i);
      pre_data = $urandom;
      model_ram[i] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;
    check_idle_outputs("reset");
    check("reset_words_done", 64'(words_done), 64'd0);
    reset = 1'b0;

    load_word(12'h010, 32'hAAAA_0001);
    load_word(12'h011, 32'hBBBB_0002);
    load_word(12'h012, 32'hCCCC_0003);
    load_word(12'h013, 32'hDDDD_0004);
    load_word(12'h020, 32'h5A5A_0020);

    for (int v = 0; v < 8; v++) begin
      run_transfer($sformatf("vec%0d", v), vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].n,
                   vecs[v].f, vecs[v].exp_busy, vecs[v].exp_done, vecs[v].poke);
      case (v)
        0: check("copy_last_word", 64'(ram[12'h103]), 64'h0000_0000_DDDD_0004);
        1: check("fill_wrap_word", 64'(ram[12'h001]), 64'h0000_0000_DEAD_BEEF);
        3: check("overlap_replicate", 64'(ram[12'h023]), 64'h0000_0000_5A5A_0020);
        default: ;
      endcase
    end

    // Reset during the WRITE of word 2 of a 4-word copy.
    for (int i = 0; i < 2; i++) model_ram[12'h700 + AW'(i)] = model_ram[12'h600 + AW'(i)];
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    src_addr = 12'h600;
    dst_addr = 12'h700;
    length = 13'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_in_write", 64'(mem_wEn), 64'd1);
    check("rst_mid_write_addr", 64'(mem_addr), 64'h702);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_words_done", 64'(words_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    compare_ram("rst_mid");
    run_transfer("post_reset", 1'b0, 12'h600, 12'h700, 13'd4, 32'h0, 8, 9, 1'b0);

    for (int t = 0; t < 12; t++) begin
      rm = 1'($urandom);
      rs = AW'($urandom);
      rd = AW'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(1, 24));
      eb = (rn == 0) ? 0 : (rm ? int'(rn) : 2 * int'(rn));
      run_transfer($sformatf("rand%0d", t), rm, rs, rd, rn, $urandom, eb, eb + 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer engine that acts as the initiating side of the single-port synchronous RAM interface: it drives write-enable, address and write data, and consumes the RAM's registered read data. It copies a run of words from one RAM region to another, or fills a region with a constant, without processor involvement. It sits between the processor's control registers (start/operands) and the data RAM port, through a mux the processor releases while `busy` is high.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; must match the RAM.
- `ADDRESS_WIDTH`, 12, RAM address width; must match the RAM.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `mode`  in  1  0 = COPY, 1 = FILL; latched with `start`.
- `src_addr`  in  ADDRESS_WIDTH  first source word (COPY only).
- `dst_addr`  in  ADDRESS_WIDTH  first destination word.
- `length`  in  ADDRESS_WIDTH+1  word count, 0..2^ADDRESS_WIDTH.
- `fill_data`  in  DATA_WIDTH  constant written in FILL mode; latched with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `words_done`  out  ADDRESS_WIDTH+1  words written so far in the current or last transfer.
- `mem_wEn`  out  1  to the RAM write enable.
- `mem_addr`  out  ADDRESS_WIDTH  to the RAM address.
- `mem_dataIn`  out  DATA_WIDTH  to the RAM write data.
- `mem_dataOut`  in  DATA_WIDTH  from the RAM read data (registered in the RAM, valid the cycle after a read is issued with `mem_wEn`=0).

## Operation
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE: `mem_wEn`=0, `mem_addr`=0, `mem_dataIn`=0, `busy`=0. On `start`=1, latch all operands and clear `words_done`. Next state: DONE if `length`=0, else READ (COPY) or FILL (FILL).
- READ: `mem_addr`=src+i, `mem_wEn`=0 → WRITE.
- WRITE: `mem_addr`=dst+i, `mem_wEn`=1, `mem_dataIn`=`mem_dataOut` (combinational pass-through). On the edge, i and `words_done` increment. Next state: DONE if i+1=length, else READ.
- FILL: `mem_addr`=dst+i, `mem_wEn`=1, `mem_dataIn`=latched `fill_data`. Increment as in WRITE. Next state: DONE when i+1=length.
- DONE: `done`=1 and `busy`=0 for exactly one cycle → IDLE.
- Address arithmetic is modulo 2^ADDRESS_WIDTH; regions wrap past the top address to 0.
- Copy order is always ascending. If the regions overlap with dst in (src, src+length), already-written words are re-read; this is defined behaviour (pattern replication), not an error.
- `start` outside IDLE is ignored; operand changes after latching have no effect.
- `words_done` holds its final value after DONE until the next accepted `start`.

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `done`=0, `words_done`=0, `mem_wEn`=0, `mem_addr`=0, `mem_dataIn`=0. Writes already performed remain in RAM. Any write whose edge has not yet occurred is cancelled.
- `busy`=1 exactly while in READ/WRITE/FILL.
- COPY of N≥1 words: `start` accepted at edge 0, `busy` for 2N cycles, `done` in cycle 2N+1, IDLE at cycle 2N+2.
- FILL of N≥1 words: `busy` for N cycles, `done` in cycle N+1.
- `length`=0: `done` in the cycle after acceptance. `busy` is never asserted and no RAM access is made.
- A new `start` is accepted at earliest in the first IDLE cycle after DONE, so back-to-back transfers have a 1-cycle IDLE gap.
- One RAM access per cycle maximum; the RAM's write cycle never updates `mem_dataOut`, so the READ→WRITE pairing is mandatory.

## Structure
- Shared package `ram_dma_pkg`: state enum and mode encodings (MODE_COPY=0, MODE_FILL=1).
- One natural sub-module, `ram_dma_counter`: loadable index counter with terminal-count compare (i+1=length), reused for `words_done`.
- The controller FSM, address adders and output muxing stay in the top module.

## Test plan
- COPY src=0x010, dst=0x100, len=4, RAM[0x10..0x13]=A,B,C,D → RAM[0x100..0x103]=A,B,C,D; `busy` 8 cycles; `done` at cycle 9; `words_done`=4.
- FILL dst=0xFFE, len=4, fill=0xDEADBEEF → addresses 0xFFE, 0xFFF, 0x000, 0x001 written (wrap); `busy` 4 cycles.
- len=0 COPY → `done` next cycle, `mem_wEn` never 1, `busy` never 1.
- Overlap COPY src=0x20, dst=0x21, len=3, RAM[0x20]=X → RAM[0x21..0x23]=X,X,X.
- Assert `start` with new operands while `busy` → ignored; first transfer completes unchanged.
- Assert `reset` during the WRITE of word 2 of 4 → outputs zero immediately; only words 0–1 written; a new `start` after reset runs normally.
